// File: rtl/freq_range_monitor.sv
// Frequency window monitor: samples freq_hz_i SAMPLE_DLY cycles after each second strobe and debounces the result.
// Optional FREQ_MON_MINMAX_EN adds min/max tracking of every evaluated sample.
module freq_range_monitor #(
   parameter int C_CNT_BW   = 32,
   parameter int SAMPLE_DLY = 16,
   parameter int GOOD_CNT   = 3,
   parameter int BAD_CNT    = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en_i,
   input  logic                sec_i,
   input  logic [C_CNT_BW-1:0] freq_hz_i,
   input  logic [C_CNT_BW-1:0] lo_hz_i,
   input  logic [C_CNT_BW-1:0] hi_hz_i,
   output logic [C_CNT_BW-1:0] freq_q_o,
   output logic                sample_vld_o,
   output logic                in_range_o,
   output logic                clk_absent_o,
   output logic                clk_ok_o,
   output logic                status_chg_o,
   output logic [15:0]         fail_cnt_o
`ifdef FREQ_MON_MINMAX_EN
   ,
   input  logic                minmax_clr_i,
   output logic [C_CNT_BW-1:0] min_hz_o,
   output logic [C_CNT_BW-1:0] max_hz_o
`endif
);

   // state  | meaning
   // IDLE   | monitor disabled
   // ARMED  | waiting for sec_i
   // DELAY  | counting down to the sample point
   // SAMPLE | freq_hz_i captured at the end of this cycle
   // EVAL   | window check and hysteresis update at the end of this cycle
   typedef enum logic [2:0] {IDLE, ARMED, DELAY, SAMPLE, EVAL} state_t;

   localparam int DLY_W = (SAMPLE_DLY > 2) ? $clog2(SAMPLE_DLY - 1) : 1;
   localparam int GW    = $clog2(GOOD_CNT + 1);
   localparam int BW    = $clog2(BAD_CNT + 1);
   localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'((SAMPLE_DLY > 2) ? SAMPLE_DLY - 2 : 0);
   localparam logic [GW-1:0]    GOOD_MAX = GW'(GOOD_CNT);
   localparam logic [BW-1:0]    BAD_MAX  = BW'(BAD_CNT);

   state_t           state;
   logic [DLY_W-1:0] dly_cnt;
   logic [GW-1:0]    good_run;
   logic [BW-1:0]    bad_run;
   logic             eval_pend;

   logic             eval_now;
   logic             win_ok;
   logic             zero;
   logic [GW-1:0]    good_nxt;
   logic [BW-1:0]    bad_nxt;
   logic             ok_nxt;

   // eval_pend rather than state==EVAL so a strobe landing in SAMPLE still gets its evaluation
   always_comb begin
      eval_now = en_i && (state != IDLE) && eval_pend;
      win_ok   = (lo_hz_i <= freq_q_o) && (freq_q_o <= hi_hz_i);
      zero     = (freq_q_o == '0);
      good_nxt = '0;
      bad_nxt  = '0;
      if (win_ok)
         good_nxt = (good_run == GOOD_MAX) ? good_run : good_run + GW'(1);
      else
         bad_nxt = (bad_run == BAD_MAX) ? bad_run : bad_run + BW'(1);
      ok_nxt = clk_ok_o;
      if (zero)
         ok_nxt = 1'b0;
      else if (win_ok && (good_nxt == GOOD_MAX))
         ok_nxt = 1'b1;
      else if (!win_ok && (bad_nxt == BAD_MAX))
         ok_nxt = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         dly_cnt      <= '0;
         good_run     <= '0;
         bad_run      <= '0;
         eval_pend    <= 1'b0;
         freq_q_o     <= '0;
         sample_vld_o <= 1'b0;
         in_range_o   <= 1'b0;
         clk_absent_o <= 1'b0;
         clk_ok_o     <= 1'b0;
         status_chg_o <= 1'b0;
         fail_cnt_o   <= '0;
      end else begin
         sample_vld_o <= 1'b0;
         status_chg_o <= 1'b0;
         if (!en_i) begin
            state        <= IDLE;
            dly_cnt      <= '0;
            good_run     <= '0;
            bad_run      <= '0;
            eval_pend    <= 1'b0;
            in_range_o   <= 1'b0;
            clk_absent_o <= 1'b0;
            clk_ok_o     <= 1'b0;
         end else if (state == IDLE) begin
            state <= ARMED;
         end else begin
            eval_pend <= (state == SAMPLE);
            if (state == SAMPLE) begin
               freq_q_o     <= freq_hz_i;
               sample_vld_o <= 1'b1;
            end
            if (eval_now) begin
               in_range_o   <= win_ok;
               clk_absent_o <= zero;
               good_run     <= good_nxt;
               bad_run      <= bad_nxt;
               clk_ok_o     <= ok_nxt;
               status_chg_o <= (ok_nxt != clk_ok_o);
               if (!win_ok && (fail_cnt_o != 16'hFFFF))
                  fail_cnt_o <= fail_cnt_o + 16'd1;
            end
            // a new strobe always restarts the delay; a pending capture in SAMPLE still completes
            if (sec_i) begin
               if (SAMPLE_DLY == 1) begin
                  state <= SAMPLE;
               end else begin
                  state   <= DELAY;
                  dly_cnt <= DLY_LOAD;
               end
            end else begin
               case (state)
                  DELAY: begin
                     if (dly_cnt == '0)
                        state <= SAMPLE;
                     else
                        dly_cnt <= dly_cnt - DLY_W'(1);
                  end
                  SAMPLE:  state <= EVAL;
                  EVAL:    state <= ARMED;
                  default: state <= state;
               endcase
            end
         end
      end
   end

`ifdef FREQ_MON_MINMAX_EN
   always_ff @(posedge clk) begin
      if (rst || minmax_clr_i) begin
         min_hz_o <= '1;
         max_hz_o <= '0;
      end else if (eval_now) begin
         if (freq_q_o < min_hz_o)
            min_hz_o <= freq_q_o;
         if (freq_q_o > max_hz_o)
            max_hz_o <= freq_q_o;
      end
   end
`endif

endmodule

// File: tb/tb_freq_range_monitor.sv
// Randomized scoreboard bench for freq_range_monitor with a time-based reference model.
module tb_freq_range_monitor;

   localparam int D  = 16;
   localparam int GC = 3;
   localparam int BC = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en_i = 1'b1;
   logic        sec_i = 1'b0;
   logic [31:0] freq_hz_i = '0;
   logic [31:0] lo_hz_i = 32'd99_000_000;
   logic [31:0] hi_hz_i = 32'd101_000_000;
   logic [31:0] freq_q_o;
   logic        sample_vld_o, in_range_o, clk_absent_o, clk_ok_o, status_chg_o;
   logic [15:0] fail_cnt_o;
`ifdef FREQ_MON_MINMAX_EN
   logic        minmax_clr_i = 1'b0;
   logic [31:0] min_hz_o, max_hz_o;
`endif

   freq_range_monitor #(.C_CNT_BW(32), .SAMPLE_DLY(D), .GOOD_CNT(GC), .BAD_CNT(BC)) dut (
      .clk(clk), .rst(rst), .en_i(en_i), .sec_i(sec_i),
      .freq_hz_i(freq_hz_i), .lo_hz_i(lo_hz_i), .hi_hz_i(hi_hz_i),
      .freq_q_o(freq_q_o), .sample_vld_o(sample_vld_o), .in_range_o(in_range_o),
      .clk_absent_o(clk_absent_o), .clk_ok_o(clk_ok_o), .status_chg_o(status_chg_o),
      .fail_cnt_o(fail_cnt_o)
`ifdef FREQ_MON_MINMAX_EN
      , .minmax_clr_i(minmax_clr_i), .min_hz_o(min_hz_o), .max_hz_o(max_hz_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [31:0] f;
   } smp_t;

   typedef struct {
      int          cyc;
      logic        inr;
      logic        abs;
      logic        ok;
      logic        chg;
      logic [15:0] fail;
      logic [31:0] mn;
      logic [31:0] mx;
   } evl_t;

   smp_t sq[$];
   evl_t eq[$];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int nvld = 0;

   // reference model state
   bit          m_idle = 1'b1;
   bit          m_pending = 1'b0;
   int          m_due = 0;
   bit          m_eval_due = 1'b0;
   logic [31:0] m_last = '0;
   bit          m_ok = 1'b0;
   int          m_good = 0;
   int          m_bad = 0;
   int          m_fail = 0;
   logic [31:0] m_min = '1;
   logic [31:0] m_max = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, exp);
      end
   endtask

   // Model: a strobe at cycle T schedules a capture at T+D, superseding any later-scheduled one;
   // the capture is judged against the window one cycle later.
   always @(posedge clk) begin
      bit   do_eval;
      bit   inr;
      bit   zero;
      evl_t e;
      cyc = cyc + 1;
      if (rst) begin
         m_idle = 1'b1; m_pending = 1'b0; m_eval_due = 1'b0; m_last = '0;
         m_ok = 1'b0; m_good = 0; m_bad = 0; m_fail = 0; m_min = '1; m_max = '0;
      end else begin
         do_eval = m_eval_due && en_i;
         m_eval_due = 1'b0;
         if (do_eval) begin
            inr  = (lo_hz_i <= m_last) && (m_last <= hi_hz_i);
            zero = (m_last == 0);
            if (inr) begin
               m_good = (m_good < GC) ? m_good + 1 : GC;
               m_bad = 0;
            end else begin
               m_bad = (m_bad < BC) ? m_bad + 1 : BC;
               m_good = 0;
               m_fail = (m_fail < 65535) ? m_fail + 1 : 65535;
            end
            e.chg = m_ok;
            if (zero) m_ok = 1'b0;
            else if (m_good >= GC) m_ok = 1'b1;
            else if (m_bad >= BC) m_ok = 1'b0;
            e.chg = (e.chg != m_ok);
            e.cyc = cyc; e.inr = inr; e.abs = zero; e.ok = m_ok; e.fail = m_fail[15:0];
         end
`ifdef FREQ_MON_MINMAX_EN
         if (minmax_clr_i) begin
            m_min = '1; m_max = '0;
         end else if (do_eval) begin
            if (m_last < m_min) m_min = m_last;
            if (m_last > m_max) m_max = m_last;
         end
`endif
         if (do_eval) begin
            e.mn = m_min; e.mx = m_max;
            eq.push_back(e);
         end
         if (!en_i) begin
            m_pending = 1'b0; m_ok = 1'b0; m_good = 0; m_bad = 0; m_idle = 1'b1;
         end else if (m_idle) begin
            m_idle = 1'b0;
         end else begin
            if (m_pending && m_due == cyc) begin
               smp_t s;
               m_last = freq_hz_i;
               s.cyc = cyc; s.f = freq_hz_i;
               sq.push_back(s);
               m_pending = 1'b0;
               m_eval_due = 1'b1;
            end
            if (sec_i) begin
               m_pending = 1'b1;
               m_due = cyc + D;
            end
         end
      end
   end

   // Monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (sample_vld_o) begin
            nvld++;
            if (sq.size() == 0) begin
               chk("sample_unexpected", 64'd1, 64'd0);
            end else begin
               smp_t s;
               s = sq.pop_front();
               chk("sample_time", 64'(cyc), 64'(s.cyc));
               chk("freq_q", 64'(freq_q_o), 64'(s.f));
            end
         end
         if (eq.size() > 0 && eq[0].cyc == cyc) begin
            evl_t e;
            e = eq.pop_front();
            chk("in_range", 64'(in_range_o), 64'(e.inr));
            chk("clk_absent", 64'(clk_absent_o), 64'(e.abs));
            chk("clk_ok", 64'(clk_ok_o), 64'(e.ok));
            chk("status_chg", 64'(status_chg_o), 64'(e.chg));
            chk("fail_cnt", 64'(fail_cnt_o), 64'(e.fail));
`ifdef FREQ_MON_MINMAX_EN
            chk("min_hz", 64'(min_hz_o), 64'(e.mn));
            chk("max_hz", 64'(max_hz_o), 64'(e.mx));
`endif
         end else begin
            chk("status_chg_quiet", 64'(status_chg_o), 64'd0);
         end
      end
   end

   task automatic strobe(input int gap);
      sec_i = 1'b1;
      @(negedge clk);
      sec_i = 1'b0;
      repeat (gap - 1) @(negedge clk);
   endtask

   function automatic logic [31:0] pick_freq(input logic [31:0] lo, input logic [31:0] hi);
      logic [31:0] f;
      case ($urandom_range(0, 9))
         0: f = lo;
         1: f = hi;
         2: f = lo - 32'd1;
         3: f = hi + 32'd1;
         4: f = 32'd0;
         5: f = $urandom;
         default: f = (lo <= hi) ? lo + ($urandom % (hi - lo + 32'd1)) : lo;
      endcase
      return f;
   endfunction

   initial begin
      int vbase;
      // reset with strobes that must be ignored
      rst = 1'b1; freq_hz_i = 32'd100_000_000;
      @(negedge clk);
      strobe(2);
      repeat (2) @(negedge clk);
      chk("rst_freq_q", 64'(freq_q_o), 64'd0);
      chk("rst_vld", 64'(sample_vld_o), 64'd0);
      chk("rst_in_range", 64'(in_range_o), 64'd0);
      chk("rst_absent", 64'(clk_absent_o), 64'd0);
      chk("rst_ok", 64'(clk_ok_o), 64'd0);
      chk("rst_chg", 64'(status_chg_o), 64'd0);
      chk("rst_fail", 64'(fail_cnt_o), 64'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // in-range run to OK
      repeat (3) strobe(20);
      chk("ok_after_3_good", 64'(clk_ok_o), 64'd1);
      chk("fail_after_good", 64'(fail_cnt_o), 64'd0);

      // two bad samples
      freq_hz_i = 32'd50_000_000;
      strobe(20);
      chk("ok_after_1_bad", 64'(clk_ok_o), 64'd1);
      chk("fail_after_1_bad", 64'(fail_cnt_o), 64'd1);
      strobe(20);
      chk("ok_after_2_bad", 64'(clk_ok_o), 64'd0);
      chk("fail_after_2_bad", 64'(fail_cnt_o), 64'd2);

      // zero sample from OK
      freq_hz_i = 32'd100_000_000;
      repeat (3) strobe(20);
      chk("ok_before_zero", 64'(clk_ok_o), 64'd1);
      freq_hz_i = 32'd0;
      strobe(20);
      chk("absent_zero", 64'(clk_absent_o), 64'd1);
      chk("ok_zero", 64'(clk_ok_o), 64'd0);

      // restart: strobe 5 cycles after the first
      freq_hz_i = 32'd100_000_000;
      vbase = nvld;
      strobe(5);
      strobe(25);
      chk("restart_vld_count", 64'(nvld - vbase), 64'd1);

      // disable mid-operation
      repeat (3) strobe(20);
      chk("ok_before_dis", 64'(clk_ok_o), 64'd1);
      en_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("dis_ok", 64'(clk_ok_o), 64'd0);
      chk("dis_in_range", 64'(in_range_o), 64'd0);
      chk("dis_fail_hold", 64'(fail_cnt_o), 64'(m_fail));
      chk("dis_freq_hold", 64'(freq_q_o), 64'(m_last));
      en_i = 1'b1;
      repeat (3) @(negedge clk);
      vbase = nvld;
      strobe(6);
      en_i = 1'b0;
      repeat (3) @(negedge clk);
      en_i = 1'b1;
      repeat (25) @(negedge clk);
      chk("dis_mid_delay_vld", 64'(nvld - vbase), 64'd0);

      // inverted window
      lo_hz_i = 32'd200; hi_hz_i = 32'd100; freq_hz_i = 32'd150;
      strobe(20);
      chk("inverted_window", 64'(in_range_o), 64'd0);

`ifdef FREQ_MON_MINMAX_EN
      minmax_clr_i = 1'b1;
      @(negedge clk);
      minmax_clr_i = 1'b0;
      lo_hz_i = 32'd0; hi_hz_i = 32'd1000;
      freq_hz_i = 32'd100; strobe(20);
      freq_hz_i = 32'd300; strobe(20);
      freq_hz_i = 32'd200; strobe(20);
      chk("min_hz", 64'(min_hz_o), 64'd100);
      chk("max_hz", 64'(max_hz_o), 64'd300);
      minmax_clr_i = 1'b1;
      @(negedge clk);
      minmax_clr_i = 1'b0;
      chk("min_clr", 64'(min_hz_o), 64'hFFFF_FFFF);
      chk("max_clr", 64'(max_hz_o), 64'd0);
`endif

      // randomized phase
      lo_hz_i = 32'd99_000_000; hi_hz_i = 32'd101_000_000;
      for (int i = 0; i < 300; i++) begin
         int gap;
         case ($urandom_range(0, 7))
            0: gap = 5;
            1: gap = D;
            2: gap = D + 1;
            3: gap = D - 1;
            default: gap = $urandom_range(D + 2, 30);
         endcase
         if ($urandom_range(0, 19) == 0) begin
            lo_hz_i = $urandom_range(0, 2000);
            hi_hz_i = $urandom_range(0, 2000);
         end else if ($urandom_range(0, 9) == 0) begin
            lo_hz_i = 32'd99_000_000; hi_hz_i = 32'd101_000_000;
         end
         freq_hz_i = pick_freq(lo_hz_i, hi_hz_i);
`ifdef FREQ_MON_MINMAX_EN
         minmax_clr_i = ($urandom_range(0, 15) == 0);
`endif
         if ($urandom_range(0, 39) == 0) begin
            en_i = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge clk);
            en_i = 1'b1;
            repeat (2) @(negedge clk);
         end
         strobe(gap);
`ifdef FREQ_MON_MINMAX_EN
         minmax_clr_i = 1'b0;
`endif
      end

      repeat (40) @(negedge clk);
      chk("samples_drained", 64'(sq.size()), 64'd0);
      chk("evals_drained", 64'(eq.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/freq_range_monitor.md
Name: freq_range_monitor

Overview:
- Downstream consumer of the per-clock frequency measurement stage, in the system clock domain.
- Samples the measured Hz value a fixed delay after each one-second strobe and checks it against a programmable [lo, hi] window.
- Applies good/bad hysteresis to produce a debounced clock-OK status, a clock-absent flag, a status-change pulse and a saturating fail counter.
- One instance per monitored clock; outputs feed status registers and the interrupt aggregator.

Parameters:
C_CNT_BW, 32, width of frequency value and thresholds
SAMPLE_DLY, 16, clk cycles from sec_i to sampling freq_hz_i (>=1); covers measurement CDC latency
GOOD_CNT, 3, consecutive in-range samples required to assert clk_ok_o (>=1)
BAD_CNT, 2, consecutive out-of-range samples required to deassert clk_ok_o (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en_i  in  1  monitor enable
sec_i  in  1  one-cycle second strobe (same strobe that drives the measurement stage)
freq_hz_i  in  C_CNT_BW  measured frequency, Hz, already in clk domain
lo_hz_i  in  C_CNT_BW  lower bound, inclusive
hi_hz_i  in  C_CNT_BW  upper bound, inclusive
freq_q_o  out  C_CNT_BW  last sampled value
sample_vld_o  out  1  one-cycle pulse: freq_q_o updated
in_range_o  out  1  last sample within window
clk_absent_o  out  1  last sample == 0
clk_ok_o  out  1  debounced status
status_chg_o  out  1  one-cycle pulse when clk_ok_o changes
fail_cnt_o  out  16  count of out-of-range samples, saturates at 16'hFFFF

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset: all outputs 0; FSM to IDLE; run counters and delay counter cleared.
- FSM states:
  - IDLE: entered while en_i=0.
  - ARMED: waits for sec_i.
  - DELAY: counts SAMPLE_DLY cycles.
  - SAMPLE: single cycle.
  - EVAL: single cycle, then back to ARMED.
- Timing, with sec_i at cycle T:
  - At T+SAMPLE_DLY, freq_q_o <= freq_hz_i and sample_vld_o=1.
  - At T+SAMPLE_DLY+1, in_range_o, clk_absent_o, clk_ok_o, status_chg_o and fail_cnt_o take their new values.
- sec_i during DELAY: restart the delay from the new strobe; the previous sample is discarded.
- sec_i during SAMPLE/EVAL: accepted and handled as if seen in ARMED (no strobe lost).
- Window check: in_range = (lo <= f) && (f <= hi), unsigned. If lo_hz_i > hi_hz_i, in_range = 0 for every value.
- Thresholds are read in the EVAL cycle only.
- Hysteresis:
  - In-range sample: good_run saturating increment, bad_run = 0.
  - Out-of-range sample: bad_run saturating increment, good_run = 0, fail_cnt_o saturating increment.
  - clk_ok_o sets when good_run reaches GOOD_CNT.
  - clk_ok_o clears when bad_run reaches BAD_CNT.
  - A zero sample clears clk_ok_o immediately, regardless of BAD_CNT.
- status_chg_o is high in exactly the cycle in which clk_ok_o takes a new value.
- en_i deasserted mid-operation: next cycle FSM to IDLE; clk_ok_o, in_range_o, clk_absent_o and the run counters clear. No status_chg_o pulse is generated. freq_q_o and fail_cnt_o hold.
- Re-enable: resumes at ARMED; the first sec_i starts a fresh sequence.

Optional Feature:
FREQ_MON_MINMAX_EN
- Defined: adds input minmax_clr_i (1 bit) and outputs min_hz_o and max_hz_o (C_CNT_BW each).
- Both outputs update in EVAL from every sample, including zero samples.
- After reset or minmax_clr_i: min_hz_o = all-ones, max_hz_o = 0.
- minmax_clr_i in the same cycle as EVAL: the clear wins, and that sample is not recorded.
- Undefined: the ports and the logic are absent.

Test Plan:
Common settings: SAMPLE_DLY=16, GOOD_CNT=3, BAD_CNT=2, lo=99_000_000, hi=101_000_000, en_i=1.
1. Reset held 5 cycles -> all outputs 0; sec_i ignored while rst=1.
2. freq=100_000_000 with three sec_i strobes -> sample_vld_o at T+16 each time; clk_ok_o=1 and status_chg_o=1 at T3+17; fail_cnt_o stays 0.
3. From OK, freq=50_000_000 -> first sample: clk_ok_o stays 1, fail_cnt_o=1; second sample: clk_ok_o=0, status_chg_o pulses, fail_cnt_o=2.
4. From OK, freq=0 -> first sample gives clk_absent_o=1 and clk_ok_o=0 at T+17.
5. Second sec_i 5 cycles after the first -> exactly one sample_vld_o, at T2+16.
6. lo=200, hi=100, freq=150 -> in_range_o=0. With FREQ_MON_MINMAX_EN, samples 100, 300, 200 -> min_hz_o=100, max_hz_o=300; minmax_clr_i -> all-ones / 0.
